// File: rtl/pipe_pkg.sv
//------------------------------------------------------------------------------
// Module   : pipe_pkg
// Brief    : Shared state encoding and default widths for the pipeline skid stage.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package pipe_pkg;

  localparam int unsigned c_DATA_W = 32;
  localparam int unsigned c_CTRL_W = 8;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    HALF  = 2'd1,
    FULL  = 2'd2
  } state_t;

endpackage

`default_nettype wire

// File: rtl/pipe_slot.sv
//------------------------------------------------------------------------------
// Module   : pipe_slot
// Brief    : One payload+control register; control can be cleared independently.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module pipe_slot #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned CTRL_W = 8
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              load,
  input  logic              clr_ctrl,
  input  logic [DATA_W-1:0] d_data,
  input  logic [CTRL_W-1:0] d_ctrl,
  output logic [DATA_W-1:0] q_data,
  output logic [CTRL_W-1:0] q_ctrl
);

  logic [DATA_W-1:0] r_data;
  logic [CTRL_W-1:0] r_ctrl;

  // Clear takes priority over load so a squashed entry never leaves live control.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_data <= '0;
      r_ctrl <= '0;
    end else begin
      if (load) begin
        r_data <= d_data;
      end
      if (clr_ctrl) begin
        r_ctrl <= '0;
      end else if (load) begin
        r_ctrl <= d_ctrl;
      end
    end
  end

  assign q_data = r_data;
  assign q_ctrl = r_ctrl;

endmodule

`default_nettype wire

// File: rtl/pipe_skid_stage.sv
//------------------------------------------------------------------------------
// Module   : pipe_skid_stage
// Brief    : Two-entry registered skid buffer between pipeline stages with flush.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module pipe_skid_stage
  import pipe_pkg::*;
#(
  parameter int unsigned DATA_W = c_DATA_W,
  parameter int unsigned CTRL_W = c_CTRL_W
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CTRL_W-1:0] in_ctrl,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [1:0]        occupancy
);

  state_t r_state;
  state_t w_state_nxt;

  logic              w_accept;
  logic              w_emit;
  logic              w_main_load;
  logic              w_main_clr;
  logic              w_skid_load;
  logic              w_skid_clr;
  logic [DATA_W-1:0] w_main_d_data;
  logic [CTRL_W-1:0] w_main_d_ctrl;
  logic [DATA_W-1:0] w_skid_data;
  logic [CTRL_W-1:0] w_skid_ctrl;

  assign in_ready  = (r_state != FULL) && resetn;
  assign out_valid = (r_state != EMPTY);
  assign occupancy = r_state;

  assign w_accept = in_valid && in_ready;
  assign w_emit   = out_valid && out_ready;

  // Only the FULL->HALF promotion refills main from skid.
  assign w_main_d_data = (r_state == FULL) ? w_skid_data : in_data;
  assign w_main_d_ctrl = (r_state == FULL) ? w_skid_ctrl : in_ctrl;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state <= EMPTY;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_main_load = 1'b0;
    w_main_clr  = 1'b0;
    w_skid_load = 1'b0;
    w_skid_clr  = 1'b0;
    case (r_state)
      EMPTY: begin
        if (w_accept) begin
          w_state_nxt = HALF;
          w_main_load = 1'b1;
        end
      end
      HALF: begin
        if (w_accept && w_emit) begin
          w_main_load = 1'b1;
        end else if (w_accept) begin
          w_state_nxt = FULL;
          w_skid_load = 1'b1;
        end else if (w_emit) begin
          // Drop main control so out_ctrl reads zero once the stage drains.
          w_state_nxt = EMPTY;
          w_main_clr  = 1'b1;
        end
      end
      FULL: begin
        if (w_emit) begin
          w_state_nxt = HALF;
          w_main_load = 1'b1;
          w_skid_clr  = 1'b1;
        end
      end
      default: begin
        w_state_nxt = EMPTY;
      end
    endcase
    if (flush) begin
      w_state_nxt = EMPTY;
      w_main_load = 1'b0;
      w_skid_load = 1'b0;
      w_main_clr  = 1'b1;
      w_skid_clr  = 1'b1;
    end
  end

  pipe_slot #(
    .DATA_W (DATA_W),
    .CTRL_W (CTRL_W)
  ) u_main_slot (
    .clk      (clk),
    .resetn   (resetn),
    .load     (w_main_load),
    .clr_ctrl (w_main_clr),
    .d_data   (w_main_d_data),
    .d_ctrl   (w_main_d_ctrl),
    .q_data   (out_data),
    .q_ctrl   (out_ctrl)
  );

  pipe_slot #(
    .DATA_W (DATA_W),
    .CTRL_W (CTRL_W)
  ) u_skid_slot (
    .clk      (clk),
    .resetn   (resetn),
    .load     (w_skid_load),
    .clr_ctrl (w_skid_clr),
    .d_data   (in_data),
    .d_ctrl   (in_ctrl),
    .q_data   (w_skid_data),
    .q_ctrl   (w_skid_ctrl)
  );

endmodule

`default_nettype wire

// File: tb/tb_pipe_skid_stage.sv
//------------------------------------------------------------------------------
// Module   : tb_pipe_skid_stage
// Brief    : Directed and randomised self-checking bench for pipe_skid_stage.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_pipe_skid_stage;

  localparam int unsigned c_DW = 32;
  localparam int unsigned c_CW = 8;

  logic            clk = 1'b0;
  logic            resetn;
  logic            flush;
  logic            in_valid;
  logic            in_ready;
  logic [c_DW-1:0] in_data;
  logic [c_CW-1:0] in_ctrl;
  logic            out_valid;
  logic            out_ready;
  logic [c_DW-1:0] out_data;
  logic [c_CW-1:0] out_ctrl;
  logic [1:0]      occupancy;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  pipe_skid_stage #(
    .DATA_W (c_DW),
    .CTRL_W (c_CW)
  ) u_dut (
    .clk       (clk),
    .resetn    (resetn),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_ctrl   (in_ctrl),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_ctrl  (out_ctrl),
    .occupancy (occupancy)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [c_DW-1:0] d, input logic [c_CW-1:0] c);
    in_valid = v;
    in_data  = d;
    in_ctrl  = c;
  endtask

  logic [c_DW+c_CW-1:0] q[$];
  logic [c_DW+c_CW-1:0] head;
  int sent;
  int got;
  logic acc;
  logic em;

  initial begin
    resetn = 1'b0; flush = 1'b0; out_ready = 1'b0;
    drive(1'b0, '0, '0);
    tick(); tick();
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_occ", occupancy, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_ctrl", out_ctrl, 0);
    resetn = 1'b1;
    #1;
    chk("rel_in_ready", in_ready, 1);

    // Streaming with downstream always ready
    out_ready = 1'b1;
    drive(1'b1, 32'h11, 8'h01); tick();
    chk("s1_data", out_data, 32'h11); chk("s1_occ", occupancy, 1);
    drive(1'b1, 32'h22, 8'h02); tick();
    chk("s2_data", out_data, 32'h22); chk("s2_occ", occupancy, 1);
    chk("s2_ctrl", out_ctrl, 8'h02);
    drive(1'b1, 32'h33, 8'h03); tick();
    chk("s3_data", out_data, 32'h33); chk("s3_occ", occupancy, 1);
    drive(1'b0, '0, '0); tick();
    chk("s_drain_occ", occupancy, 0);
    chk("s_drain_ctrl", out_ctrl, 0);

    // Backpressure
    out_ready = 1'b0;
    drive(1'b1, 32'hA, 8'h0A); tick();
    chk("bp_a_occ", occupancy, 1);
    drive(1'b1, 32'hB, 8'h0B); tick();
    chk("bp_b_occ", occupancy, 2);
    chk("bp_full_rdy", in_ready, 0);
    drive(1'b1, 32'hC, 8'h0C); tick();
    chk("bp_hold_occ", occupancy, 2);
    chk("bp_hold_data", out_data, 32'hA);
    out_ready = 1'b1; tick();
    chk("bp_out_b", out_data, 32'hB); chk("bp_occ_b", occupancy, 1);
    tick();
    chk("bp_out_c", out_data, 32'hC); chk("bp_ctrl_c", out_ctrl, 8'h0C);
    drive(1'b0, '0, '0); tick();
    chk("bp_empty", occupancy, 0);

    // Flush while full with a new entry offered
    out_ready = 1'b0;
    drive(1'b1, 32'h51, 8'h51); tick();
    drive(1'b1, 32'h52, 8'h52); tick();
    chk("fl_pre_occ", occupancy, 2);
    drive(1'b1, 32'h53, 8'h53); flush = 1'b1; out_ready = 1'b1; tick();
    flush = 1'b0; drive(1'b0, '0, '0);
    chk("fl_occ", occupancy, 0);
    chk("fl_valid", out_valid, 0);
    chk("fl_ctrl", out_ctrl, 0);
    tick();
    chk("fl_not_stored", occupancy, 0);

    // Asynchronous reset mid-cycle while HALF
    out_ready = 1'b0;
    drive(1'b1, 32'hDEAD, 8'hFF); tick();
    drive(1'b0, '0, '0);
    chk("ar_pre_ctrl", out_ctrl, 8'hFF);
    #2 resetn = 1'b0;
    #1;
    chk("ar_valid", out_valid, 0);
    chk("ar_ctrl", out_ctrl, 0);
    chk("ar_in_ready", in_ready, 0);
    tick();
    chk("ar_hold_rdy", in_ready, 0);
    resetn = 1'b1;
    #1;
    chk("ar_rel_rdy", in_ready, 1);
    tick();

    // Random valid/ready against a queue model
    sent = 0; got = 0;
    for (int cyc = 0; cyc < 20000 && got < 1000; cyc++) begin
      drive((sent < 1000) && ($urandom_range(0, 1) == 1), $urandom, 8'($urandom_range(0, 255)));
      out_ready = ($urandom_range(0, 1) == 1);
      chk("r_occ", occupancy, q.size());
      chk("r_valid", out_valid, q.size() != 0);
      chk("r_in_ready", in_ready, q.size() < 2);
      if (q.size() != 0) begin
        head = q[0];
        chk("r_data", out_data, head[c_DW+c_CW-1:c_CW]);
        chk("r_ctrl", out_ctrl, head[c_CW-1:0]);
      end else begin
        chk("r_ctrl_idle", out_ctrl, 0);
      end
      acc = in_valid && (q.size() < 2);
      em  = (q.size() != 0) && out_ready;
      tick();
      if (em) begin
        void'(q.pop_front());
        got++;
      end
      if (acc) begin
        q.push_back({in_data, in_ctrl});
        sent++;
      end
    end
    chk("r_all_received", got, 1000);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/pipe_skid_stage.md
PIPE_SKID_STAGE -- requirements
Module: pipe_skid_stage

Interface
REQ-001 Parameter DATA_W, default 32: width of payload bus (ALU result, store data, PC+4 packed by the instantiating stage).
REQ-002 Parameter CTRL_W, default 8: width of control bundle (write enables, result-mux select, load/store commands).
REQ-003 The block SHALL use one clock and an asynchronous, active-low reset. Ports: clk, resetn.
REQ-004 clk  in  1  rising-edge clock for all state.
REQ-005 resetn  in  1  asynchronous active-low reset.
REQ-006 flush  in  1  synchronous kill of all held entries (branch/exception squash).
REQ-007 in_valid  in  1  upstream entry present.
REQ-008 in_ready  out  1  stage can accept an entry this cycle.
REQ-009 in_data  in  DATA_W  upstream payload.
REQ-010 in_ctrl  in  CTRL_W  upstream control bundle.
REQ-011 out_valid  out  1  head entry present downstream.
REQ-012 out_ready  in  1  downstream consumes head this cycle.
REQ-013 out_data  out  DATA_W  head payload.
REQ-014 out_ctrl  out  CTRL_W  head control; all-zero whenever out_valid=0.
REQ-015 occupancy  out  2  entries held (0, 1 or 2).

Function
REQ-016 Accept SHALL occur on a rising edge with in_valid=1 and in_ready=1; emit SHALL occur on a rising edge with out_valid=1 and out_ready=1.
REQ-017 Storage SHALL be two slots: main (head) and skid; FSM states EMPTY, HALF, FULL.
REQ-018 EMPTY: accept -> HALF, main <= input; else stay.
REQ-019 HALF: accept+emit -> HALF, main <= input; accept only -> FULL, skid <= input; emit only -> EMPTY; neither -> stay.
REQ-020 FULL: emit -> HALF, main <= skid; no emit -> stay; no accept possible.
REQ-021 in_ready SHALL equal (state != FULL) AND resetn, with no combinational path from out_ready or in_valid.
REQ-022 out_valid SHALL equal (state != EMPTY); out_data/out_ctrl SHALL come directly from main slot flops.
REQ-023 Latency: entry accepted at edge N SHALL appear on out_* after edge N; sustained throughput one entry per cycle with out_ready=1.
REQ-024 Ordering SHALL be strict FIFO; no entry dropped or duplicated except under flush.
REQ-025 flush=1 SHALL force next state EMPTY and clear both control slots to zero; any accept or emit in the same cycle SHALL be discarded (flush wins).
REQ-026 Payload slots SHALL NOT be cleared by flush (don't-care while invalid).
REQ-027 occupancy SHALL be 0/1/2 for EMPTY/HALF/FULL; value 3 SHALL never appear.

Reset
REQ-028 resetn=0 SHALL asynchronously set state EMPTY, all slot flops zero, out_valid=0, out_ctrl=0, out_data=0, occupancy=0, in_ready=0.
REQ-029 After resetn deasserts, in_ready SHALL be 1 on the first cycle; reset asserted mid-transfer SHALL discard all held entries.

Structure
REQ-030 Shared package pipe_pkg SHALL hold state typedef (EMPTY=2'd0, HALF=2'd1, FULL=2'd2) and default DATA_W/CTRL_W constants.
REQ-031 One sub-module pipe_slot (DATA_W+CTRL_W register with load and control-clear inputs, async reset) SHALL be instantiated twice.

Verification
REQ-032 Streaming: out_ready=1, inputs 0x11,0x22,0x33 on consecutive cycles -> same values on out_data one cycle later each, occupancy stays 1.
REQ-033 Backpressure: out_ready=0, push 0xA, 0xB -> occupancy 2, in_ready=0; 0xC held at input; out_ready=1 -> outputs 0xA, 0xB, 0xC in order, none lost.
REQ-034 Flush while FULL with in_valid=1 -> next cycle occupancy 0, out_valid=0, out_ctrl=0, offered entry not stored.
REQ-035 Async reset mid-cycle while HALF with ctrl=0xFF -> out_valid and out_ctrl drop to 0 without clock edge; in_ready=0 until resetn=1.
REQ-036 Randomised valid/ready (50%) over 1000 entries -> scoreboard order match, occupancy never 3, out_ctrl=0 whenever out_valid=0.
